// File: rtl/uart_rx_core.sv
// uart_rx_core
//   UART receiver, 8 data bits, 1 stop bit, LSB first, followed by a
//   first-word-fall-through receive FIFO with a valid/ready read port.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     When defined, a parity bit can be expected between the data bits and
//     the stop bit (cfg_parity_en / cfg_parity_odd); a mismatch pulses
//     err_parity_o and the byte is not pushed.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   cfg_en              receiver enable; low forces the FSM back to IDLE
//   cfg_div             clock cycles per bit (>= 4), latched at frame start
//   rx_i                serial line, idle high, asynchronous to clk
//   rx_data_o           head-of-FIFO byte
//   rx_valid_o          FIFO not empty
//   rx_ready_i          pops the head when rx_valid_o is also high
//   fifo_level_o        FIFO occupancy, 0..FIFO_DEPTH
//   busy_o              FSM not in IDLE
//   err_frame_o         1-cycle pulse: stop bit sampled low
//   err_overrun_o       1-cycle pulse: good byte dropped because FIFO full
//   cfg_parity_en, cfg_parity_odd, err_parity_o   (UART_RX_PARITY_EN only)
module uart_rx_core #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_en,
    input  logic [DIV_W-1:0]            cfg_div,
`ifdef UART_RX_PARITY_EN
    input  logic                        cfg_parity_en,
    input  logic                        cfg_parity_odd,
    output logic                        err_parity_o,
`endif
    input  logic                        rx_i,
    output logic [7:0]                  rx_data_o,
    output logic                        rx_valid_o,
    input  logic                        rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
    output logic                        busy_o,
    output logic                        err_frame_o,
    output logic                        err_overrun_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser; flops reset to the idle line level so reset
    // release never looks like a start bit.
    // ------------------------------------------------------------------
    logic rx_meta, rxs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rxs     <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             push_pend;   // good byte in shreg, FIFO writes it next edge
    logic             par_ok;

    logic [DIV_W-1:0] half_m1, full_m1;
    assign half_m1 = (div_q >> 1) - DIV_W'(1);
    assign full_m1 = div_q - DIV_W'(1);

`ifdef UART_RX_PARITY_EN
    logic par_en_q, par_odd_q, par_bad;
    assign par_ok = ~par_bad;
`else
    assign par_ok = 1'b1;
`endif

    assign busy_o = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            div_q       <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            push_pend   <= 1'b0;
            err_frame_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            par_bad      <= 1'b0;
            err_parity_o <= 1'b0;
`endif
        end else begin
            push_pend   <= 1'b0;
            err_frame_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
            err_parity_o <= 1'b0;
`endif
            if (!cfg_en) begin
                // Partial frame discarded; FIFO is untouched.
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!rxs) begin
                            state <= S_START;
                            cnt   <= '0;
                            div_q <= cfg_div;
`ifdef UART_RX_PARITY_EN
                            par_en_q  <= cfg_parity_en;
                            par_odd_q <= cfg_parity_odd;
                            par_bad   <= 1'b0;
`endif
                        end
                    end
                    S_START: begin
                        // Mid-bit recheck rejects short low glitches.
                        if (cnt == half_m1) begin
                            if (rxs) begin
                                state <= S_IDLE;
                            end else begin
                                state   <= S_DATA;
                                bit_idx <= '0;
                                cnt     <= '0;
                            end
                        end else begin
                            cnt <= cnt + DIV_W'(1);
                        end
                    end
                    S_DATA: begin
                        if (cnt == full_m1) begin
                            shreg[bit_idx] <= rxs;
                            cnt            <= '0;
                            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= par_en_q ? S_PARITY : S_STOP;
`else
                                state <= S_STOP;
`endif
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            cnt <= cnt + DIV_W'(1);
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    S_PARITY: begin
                        if (cnt == full_m1) begin
                            cnt   <= '0;
                            state <= S_STOP;
                            // Total ones count (data + parity bit) must be odd
                            // for odd parity, even otherwise.
                            if ((^shreg ^ rxs) != par_odd_q) begin
                                err_parity_o <= 1'b1;
                                par_bad      <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + DIV_W'(1);
                        end
                    end
`endif
                    S_STOP: begin
                        if (cnt == full_m1) begin
                            if (rxs) begin
                                state     <= S_IDLE;
                                push_pend <= par_ok;
                            end else begin
                                err_frame_o <= 1'b1;
                                state       <= S_BREAK;
                            end
                        end else begin
                            cnt <= cnt + DIV_W'(1);
                        end
                    end
                    S_BREAK: begin
                        // A line held low must return high before a new frame.
                        if (rxs) state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // FWFT receive FIFO. shreg is stable during the push cycle because the
    // FSM cannot reach DATA again within one cycle of leaving STOP.
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_nxt;
    logic          pop, full, wr_ok;

    assign pop       = rx_valid_o & rx_ready_i;
    assign full      = (fifo_level_o == LW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_ok     = push_pend & (~full | pop);
    assign level_nxt = fifo_level_o + LW'(wr_ok) - LW'(pop);
    assign rx_data_o = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level_o  <= '0;
            rx_valid_o    <= 1'b0;
            err_overrun_o <= 1'b0;
        end else begin
            err_overrun_o <= push_pend & full & ~pop;
            if (wr_ok) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_level_o <= level_nxt;
            rx_valid_o   <= (level_nxt != '0);
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core
//   Directed and randomized frames driven onto rx_i; received bytes are
//   compared against a queue-based model of an 8-deep receive buffer.
module tb_uart_rx_core;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_en = 1'b0;
    logic [15:0] cfg_div = 16'd16;
    logic        rx = 1'b1;
    logic        rx_ready = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [3:0]  level;
    logic        busy, err_frame, err_overrun;
`ifdef UART_RX_PARITY_EN
    logic        cfg_parity_en = 1'b0;
    logic        cfg_parity_odd = 1'b0;
    logic        err_parity;
`endif

    uart_rx_core #(.FIFO_DEPTH(D), .DIV_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_en        (cfg_en),
        .cfg_div       (cfg_div),
`ifdef UART_RX_PARITY_EN
        .cfg_parity_en (cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd),
        .err_parity_o  (err_parity),
`endif
        .rx_i          (rx),
        .rx_data_o     (rx_data),
        .rx_valid_o    (rx_valid),
        .rx_ready_i    (rx_ready),
        .fifo_level_o  (level),
        .busy_o        (busy),
        .err_frame_o   (err_frame),
        .err_overrun_o (err_overrun)
    );

    always #5 clk = ~clk;

    int total = 0, fails = 0;
    int n_frame = 0, n_over = 0, n_par = 0;
    int exp_frame = 0, exp_over = 0, exp_par = 0;
    logic [7:0] mq[$];

    // Pulse counters: a pulse longer than one cycle shows up as extra counts.
    always @(negedge clk) begin
        if (err_frame)   n_frame++;
        if (err_overrun) n_over++;
`ifdef UART_RX_PARITY_EN
        if (err_parity)  n_par++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: a completed good frame enters the buffer unless it is full.
    task automatic model_frame(input logic [7:0] b);
        if (mq.size() < D) mq.push_back(b);
        else exp_over++;
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // par < 0: no parity bit; otherwise par[0] is sent as the parity bit.
    task automatic send(input logic [7:0] b, input int div, input logic stop, input int par);
        hold(1'b0, div);
        for (int i = 0; i < 8; i++) hold(b[i], div);
        if (par >= 0) hold(par[0], div);
        hold(stop, div);
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int t;
        t = 0;
        while (busy !== lvl && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) chk(tag, 32'(busy), 32'(lvl));
    endtask

    task automatic pop_one();
        logic [7:0] e;
        e = mq.pop_front();
        @(negedge clk);
        chk("pop_valid", 32'(rx_valid), 32'd1);
        chk("pop_data", 32'(rx_data), 32'(e));
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        chk({tag, "_level"}, 32'(level), 32'(mq.size()));
        while (mq.size() > 0) pop_one();
        @(negedge clk);
        chk({tag, "_empty"}, 32'(rx_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] b;
        int div, lvl0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_errs", {29'd0, err_frame, err_overrun, 1'b0}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cfg_en = 1'b1;
        hold(1'b1, 5);

        // 1: 0xA5 at div 16; valid within 2 clk of the stop sample (busy fall)
        cfg_div = 16'd16;
        fork
            send(8'hA5, 16, 1'b1, -1);
            begin
                wait_busy(1'b1, "t1_busy_rise");
                wait_busy(1'b0, "t1_busy_fall");
                chk("t1_valid_early", 32'(rx_valid), 32'd0);
                repeat (2) @(negedge clk);
                chk("t1_valid_2clk", 32'(rx_valid), 32'd1);
            end
        join
        model_frame(8'hA5);
        hold(1'b1, 4);
        chk("t1_level", 32'(level), 32'd1);
        drain("t1");

        // 2: 4-clk low glitch
        hold(1'b0, 4);
        hold(1'b1, 40);
        @(negedge clk);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_level", 32'(level), 32'd0);
        chk("t2_frame", 32'(n_frame), 32'(exp_frame));
        @(posedge clk);
        #1;

        // 3: framing error, long break, then a good frame
        send(8'h3C, 16, 1'b0, -1);
        exp_frame++;
        hold(1'b0, 100);
        hold(1'b1, 10);
        send(8'h11, 16, 1'b1, -1);
        model_frame(8'h11);
        hold(1'b1, 20);
        chk("t3_frame", 32'(n_frame), 32'(exp_frame));
        drain("t3");

        // 4a: nine bytes into an 8-deep buffer with no reads
        for (int i = 0; i < 9; i++) begin
            send(8'(i), 16, 1'b1, -1);
            model_frame(8'(i));
            hold(1'b1, 20);
        end
        chk("t4_over", 32'(n_over), 32'(exp_over));
        drain("t4a");

        // 4b: ninth push coincides with a pop -> no overrun
        for (int i = 0; i < 8; i++) begin
            send(8'(i), 16, 1'b1, -1);
            model_frame(8'(i));
            hold(1'b1, 20);
        end
        fork
            send(8'h08, 16, 1'b1, -1);
            begin
                wait_busy(1'b1, "t4b_busy_rise");
                wait_busy(1'b0, "t4b_busy_fall");
                chk("t4b_head", 32'(rx_data), 32'(mq[0]));
                rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
                void'(mq.pop_front());
                model_frame(8'h08);
            end
        join
        hold(1'b1, 20);
        chk("t4b_level", 32'(level), 32'd8);
        chk("t4b_over", 32'(n_over), 32'(exp_over));
        drain("t4b");

        // cfg_div change mid-frame has no effect
        fork
            send(8'hC3, 16, 1'b1, -1);
            begin
                repeat (30) @(posedge clk);
                #1 cfg_div = 16'd7;
            end
        join
        model_frame(8'hC3);
        hold(1'b1, 20);
        drain("div_chg");
        cfg_div = 16'd16;

        // cfg_en dropped mid-frame: frame discarded
        hold(1'b0, 16);
        hold(1'b1, 16);
        hold(1'b0, 10);
        cfg_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("en_busy", 32'(busy), 32'd0);
        hold(1'b0, 40);
        hold(1'b1, 120);
        cfg_en = 1'b1;
        hold(1'b1, 10);
        chk("en_level", 32'(level), 32'd0);
        chk("en_frame", 32'(n_frame), 32'(exp_frame));

        // 5: reset mid-DATA with two bytes queued
        send(8'h12, 16, 1'b1, -1);
        hold(1'b1, 20);
        send(8'h34, 16, 1'b1, -1);
        hold(1'b1, 20);
        chk("t5_pre_level", 32'(level), 32'd2);
        hold(1'b0, 16);
        hold(1'b0, 16);
        hold(1'b1, 8);
        rst_n = 1'b0;
        mq.delete();
        @(negedge clk);
        chk("t5_data", 32'(rx_data), 32'd0);
        chk("t5_valid", 32'(rx_valid), 32'd0);
        chk("t5_level", 32'(level), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_errs", {30'd0, err_frame, err_overrun}, 32'd0);
        hold(1'b1, 5);
        rst_n = 1'b1;
        hold(1'b1, 10);
        send(8'h77, 16, 1'b1, -1);
        model_frame(8'h77);
        hold(1'b1, 20);
        drain("t5");

`ifdef UART_RX_PARITY_EN
        // 6: odd parity, bad then good parity bit for 0x01
        cfg_parity_en = 1'b1;
        cfg_parity_odd = 1'b1;
        send(8'h01, 16, 1'b1, 1);
        exp_par++;
        hold(1'b1, 20);
        chk("t6_par", 32'(n_par), 32'(exp_par));
        chk("t6_nopush", 32'(level), 32'd0);
        send(8'h01, 16, 1'b1, 0);
        model_frame(8'h01);
        hold(1'b1, 20);
        chk("t6_par2", 32'(n_par), 32'(exp_par));
        drain("t6");
        cfg_parity_en = 1'b0;
`endif

        // Random bytes, random divisors, sporadic reads
        for (int r = 0; r < 14; r++) begin
            div = $urandom_range(4, 24);
            b = 8'($urandom);
            cfg_div = 16'(div);
            send(b, div, 1'b1, -1);
            model_frame(b);
            hold(1'b1, div + 4);
            lvl0 = $urandom_range(0, 2);
            if (lvl0 == 0 && mq.size() > 0) pop_one();
        end
        chk("rnd_over", 32'(n_over), 32'(exp_over));
        chk("rnd_frame", 32'(n_frame), 32'(exp_frame));
        drain("rnd");

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
